// File: rtl/alu_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one external
// combinational ALU: accept one request, run it for a cycle, return the result.
module alu_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 5,
  parameter int OP_W    = 5,
  parameter int CNT_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_opa,
  input  logic [DATA_W*NUM_REQ-1:0] req_opb,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_operand_a,
  output logic [DATA_W-1:0]         alu_operand_b,
  output logic [OP_W-1:0]           alu_operation_sel,
  output logic                      alu_cin,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               cin_q, cin_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic [DATA_W-1:0]  sel_opa;
  logic [DATA_W-1:0]  sel_opb;
  logic [OP_W-1:0]    sel_op;
  logic               sel_cin;
  logic               op_err;

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign pick_oh  = NUM_REQ'(1) << pick_idx;
  assign grant_oh = NUM_REQ'(1) << grant_q;

  assign sel_opa = DATA_W'(req_opa >> (pick_idx * DATA_W));
  assign sel_opb = DATA_W'(req_opb >> (pick_idx * DATA_W));
  assign sel_op  = OP_W'(req_op >> (pick_idx * OP_W));
  assign sel_cin = req_cin[pick_idx];

  // Opcodes above 14 are undefined; 3 (remainder) and 13 (divide) fault on B == 0.
  assign op_err = (op_q > OP_W'(14)) ||
                  (((op_q == OP_W'(3)) || (op_q == OP_W'(13))) && (opb_q == '0));

  // Handshakes: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a response transfers on an edge where rsp_valid[g] && rsp_ready[g]. Both
  // ready/valid vectors are one-hot or zero, and requesters hold inputs until taken.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    cin_d        = cin_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
    req_ready    = '0;
    rsp_valid    = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready    = pick_oh;
          opa_d        = sel_opa;
          opb_d        = sel_opb;
          op_d         = sel_op;
          cin_d        = sel_cin;
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_result;
        rsp_err_d  = op_err;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = grant_oh;
        if (rsp_ready[grant_q]) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      cin_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      cin_q        <= cin_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_operand_a     = opa_q;
  assign alu_operand_b     = opb_q;
  assign alu_operation_sel = op_q;
  assign alu_cin           = cin_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign ops_done          = ops_done_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed plan steps followed by randomized traffic,
// checked against a request-level model of arbitration, ALU and error rules.
module tb_alu_arbiter;
  localparam int N  = 3;
  localparam int DW = 5;
  localparam int OW = 5;
  localparam int CW = 8;
  localparam int PW = N * DW;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [PW-1:0] req_opa;
  logic [PW-1:0] req_opb;
  logic [PW-1:0] req_op;
  logic [N-1:0]  req_cin;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [DW-1:0] alu_operand_a;
  logic [DW-1:0] alu_operand_b;
  logic [OW-1:0] alu_operation_sel;
  logic          alu_cin;
  logic [DW-1:0] alu_result;
  logic          busy;
  logic [CW-1:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  int model_ops;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] obs_data;
  logic          obs_err;

  always #5 clock = ~clock;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation_sel(alu_operation_sel), .alu_cin(alu_cin),
    .alu_result(alu_result), .busy(busy), .ops_done(ops_done)
  );

  // Bench-side ALU: 0 add, 1 sub, 2 mul, 3 rem, 4 and, 5 or, 6 xor, 7 not,
  // 8 shl, 9 shr, 10 inc, 11 dec, 12 pass B, 13 div, 14 less-than; else 0.
  function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic cin);
    case (op)
      5'd0:  alu_ref = a + b + {4'd0, cin};
      5'd1:  alu_ref = a - b;
      5'd2:  alu_ref = DW'(a * b);
      5'd3:  alu_ref = (b == 0) ? '0 : a % b;
      5'd4:  alu_ref = a & b;
      5'd5:  alu_ref = a | b;
      5'd6:  alu_ref = a ^ b;
      5'd7:  alu_ref = ~a;
      5'd8:  alu_ref = a << 1;
      5'd9:  alu_ref = a >> 1;
      5'd10: alu_ref = a + 5'd1;
      5'd11: alu_ref = a - 5'd1;
      5'd12: alu_ref = b;
      5'd13: alu_ref = (b == 0) ? '0 : a / b;
      5'd14: alu_ref = (a < b) ? 5'd1 : 5'd0;
      default: alu_ref = '0;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_operation_sel, alu_operand_a, alu_operand_b, alu_cin);

  function automatic logic err_ref(input logic [OW-1:0] op, input logic [DW-1:0] b);
    int o;
    o = int'(op);
    err_ref = (o > 14) || ((o == 3 || o == 13) && b == 0);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    oh = N'(1) << i;
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    bit_of = t[0];
  endfunction

  function automatic logic [DW-1:0] get_slice(input logic [PW-1:0] v, input int i);
    logic [PW-1:0] t;
    t = v >> (i * DW);
    get_slice = t[DW-1:0];
  endfunction

  function automatic logic [PW-1:0] put_slice(input logic [PW-1:0] v, input int i,
                                              input logic [DW-1:0] x);
    logic [PW-1:0] m;
    logic [PW-1:0] w;
    m = {{(PW-DW){1'b0}}, {DW{1'b1}}} << (i * DW);
    w = {{(PW-DW){1'b0}}, x} << (i * DW);
    put_slice = (v & ~m) | w;
  endfunction

  // Round-robin rule: first requesting index after the previous winner, wrapping.
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    pick = -1;
    for (int k = 1; k <= N; k++)
      if (pick < 0 && bit_of(mask, (ptr + k) % N)) pick = (ptr + k) % N;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op, input logic cin);
    req_valid = req_valid | oh(i);
    req_opa   = put_slice(req_opa, i, a);
    req_opb   = put_slice(req_opb, i, b);
    req_op    = put_slice(req_op, i, op);
    req_cin   = cin ? (req_cin | oh(i)) : (req_cin & ~oh(i));
  endtask

  task automatic set_rand_req(input int i);
    logic [OW-1:0] op;
    op = ($urandom_range(0, 7) == 0) ? OW'($urandom_range(15, 31)) : OW'($urandom_range(0, 14));
    set_req(i, DW'($urandom_range(0, 31)), DW'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31)),
            op, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    model_ptr = N - 1;
    model_ops = 0;
    exp_q.delete();
  endtask

  // Called at a negedge in IDLE with at least one req_valid set; returns at the
  // negedge after the response is taken, with the arbiter back in IDLE.
  task automatic transact(input int hold, input logic [N-1:0] wrong, output int g);
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    logic          cin;
    logic [DW:0]   item;
    #1;
    g = pick(req_valid, model_ptr);
    check("grant_req_ready", req_ready, oh(g));
    check("idle_busy", busy, 0);
    a   = get_slice(req_opa, g);
    b   = get_slice(req_opb, g);
    op  = get_slice(req_op, g);
    cin = bit_of(req_cin, g);
    exp_q.push_back({err_ref(op, b), alu_ref(op, a, b, cin)});
    model_ptr = g;
    @(negedge clock);
    check("exec_busy", busy, 1);
    check("exec_req_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("alu_operand_a", alu_operand_a, a);
    check("alu_operand_b", alu_operand_b, b);
    check("alu_operation_sel", alu_operation_sel, op);
    check("alu_cin", alu_cin, cin);
    @(negedge clock);
    item     = exp_q.pop_front();
    obs_data = rsp_data;
    obs_err  = rsp_err;
    check("rsp_valid", rsp_valid, oh(g));
    check("rsp_data", rsp_data, item[DW-1:0]);
    check("rsp_err", rsp_err, item[DW]);
    check("resp_req_ready", req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = wrong & ~oh(g);
      @(negedge clock);
      check("hold_rsp_valid", rsp_valid, oh(g));
      check("hold_rsp_data", rsp_data, item[DW-1:0]);
      check("hold_busy", busy, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_ops_done", ops_done, model_ops);
    end
    rsp_ready = oh(g) | wrong;
    @(negedge clock);
    rsp_ready = '0;
    model_ops = (model_ops + 1) % (1 << CW);
    check("done_ops_done", ops_done, model_ops);
    check("done_busy", busy, 0);
    check("done_rsp_valid", rsp_valid, 0);
  endtask

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] data;
    logic          err;
  } err_case_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    err_case_t ec[6];
    logic [N-1:0] keep;
    reset     = 1'b1;
    req_valid = '0;
    req_opa   = '0;
    req_opb   = '0;
    req_op    = '0;
    req_cin   = '0;
    rsp_ready = '0;
    do_reset();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_a", alu_operand_a, 0);
    check("rst_alu_b", alu_operand_b, 0);
    check("rst_alu_op", alu_operation_sel, 0);
    check("rst_alu_cin", alu_cin, 0);
    check("rst_busy", busy, 0);
    check("rst_ops_done", ops_done, 0);
    @(negedge clock);

    // Single request from requester 1: 3 + 4.
    set_req(1, 5'd3, 5'd4, 5'd0, 1'b0);
    transact(0, '0, g);
    req_valid = '0;
    check("single_data", obs_data, 7);
    check("single_err", obs_err, 0);
    check("single_ops_done", ops_done, 1);

    // Contention: everyone requesting, granted requester refreshes its operands.
    do_reset();
    for (int i = 0; i < N; i++) set_rand_req(i);
    for (int k = 0; k < 6; k++) begin
      transact(0, '0, g);
      set_rand_req(g);
    end
    check("contention_ops_done", ops_done, 6);
    req_valid = '0;

    // Backpressure for five cycles on requester 0.
    set_req(0, 5'd9, 5'd2, 5'd1, 1'b0);
    transact(5, '0, g);
    req_valid = '0;
    check("bp_data", obs_data, 7);

    // Error flag boundaries.
    ec[0] = '{5'b01101, 5'd7, 5'd0, 5'd0, 1'b1};
    ec[1] = '{5'b11111, 5'd7, 5'd2, 5'd0, 1'b1};
    ec[2] = '{5'b00010, 5'd3, 5'd5, 5'd15, 1'b0};
    ec[3] = '{5'b01110, 5'd2, 5'd6, 5'd1, 1'b0};
    ec[4] = '{5'b01111, 5'd2, 5'd6, 5'd0, 1'b1};
    ec[5] = '{5'b00011, 5'd9, 5'd0, 5'd0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      set_req(i % N, ec[i].a, ec[i].b, ec[i].op, 1'b0);
      transact(0, '0, g);
      req_valid = '0;
      check("errcase_data", obs_data, ec[i].data);
      check("errcase_err", obs_err, ec[i].err);
    end

    // Wrong-index ready while requester 2 holds the response.
    set_req(2, 5'd5, 5'd6, 5'd4, 1'b0);
    transact(3, 3'b001, g);
    req_valid = '0;

    // Reset while EXEC: response discarded, pointer back to N-1.
    set_req(0, 5'd1, 5'd1, 5'd0, 1'b0);
    @(negedge clock);
    check("midop_exec_busy", busy, 1);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clock);
    reset     = 1'b0;
    model_ptr = N - 1;
    model_ops = 0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      check("midop_no_rsp", rsp_valid, 0);
      check("midop_idle", busy, 0);
      @(negedge clock);
    end
    check("midop_ops_done", ops_done, 0);
    set_req(2, 5'd10, 5'd3, 5'd0, 1'b1);
    transact(0, '0, g);
    set_req(0, 5'd4, 5'd4, 5'd6, 1'b0);
    transact(0, '0, g);
    req_valid = '0;

    // Randomized traffic with random backpressure and stray ready bits.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        req_valid = '0;
        #1;
        check("idle_no_ready", req_ready, 0);
        @(negedge clock);
        check("idle_not_busy", busy, 0);
      end
      keep = req_valid & ~oh(g);
      for (int i = 0; i < N; i++) begin
        if (bit_of(keep, i)) begin
          if ($urandom_range(0, 3) == 0) req_valid = req_valid & ~oh(i);
        end else if ($urandom_range(0, 1) == 1) begin
          set_rand_req(i);
        end else begin
          req_valid = req_valid & ~oh(i);
        end
      end
      if (req_valid == '0) set_rand_req($urandom_range(0, N - 1));
      transact($urandom_range(0, 3), N'($urandom_range(0, (1 << N) - 1)), g);
    end
    req_valid = '0;
    @(negedge clock);
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
